// File: rtl/eth_f_seg_traffic_gen.sv
// ============================================================================
//  Module   : eth_f_seg_traffic_gen
//  Brief    : Segmented-MAC packet generator with fixed-length, counted or
//             continuous runs of deterministic-pattern packets.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_f_seg_traffic_gen #(
  parameter int NUM_SEG   = 16,
  parameter int PKT_LEN_W = 14,
  parameter int CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic                   cfg_half,
  input  logic [PKT_LEN_W-1:0]   cfg_pkt_len,
  input  logic [CNT_W-1:0]       cfg_pkt_num,
  input  logic [7:0]             cfg_ipg,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [NUM_SEG*64-1:0]  tx_data,
  output logic [NUM_SEG-1:0]     tx_inframe,
  output logic [NUM_SEG*3-1:0]   tx_eop_empty,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       pkt_cnt
);

  localparam logic [PKT_LEN_W-1:0] c_len_min  = PKT_LEN_W'(64);
  localparam logic [PKT_LEN_W-1:0] c_len_max  = PKT_LEN_W'(9600);
  localparam logic [PKT_LEN_W-1:0] c_bpb_full = PKT_LEN_W'(8 * NUM_SEG);
  localparam logic [PKT_LEN_W-1:0] c_bpb_half = PKT_LEN_W'(4 * NUM_SEG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_IPG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_half;
  logic [PKT_LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]       r_num;
  logic [7:0]             r_ipg;
  logic [7:0]             r_gap;
  logic                   r_stop;
  logic [PKT_LEN_W-1:0]   r_off;

  logic [PKT_LEN_W-1:0]   w_bpb;
  logic [PKT_LEN_W-1:0]   w_rem;
  logic [PKT_LEN_W-1:0]   w_nb;
  logic [PKT_LEN_W-1:0]   w_last_seg;
  logic [2:0]             w_pad;
  logic                   w_eop;
  logic                   w_hs;
  logic                   w_start;
  logic                   w_load_gap;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [PKT_LEN_W-1:0]   w_len_clamp;

  assign w_bpb      = r_half ? c_bpb_half : c_bpb_full;
  assign w_rem      = r_len - r_off;
  assign w_eop      = (w_rem <= w_bpb);
  assign w_nb       = w_eop ? w_rem : w_bpb;
  assign w_last_seg = (w_nb - PKT_LEN_W'(1)) >> 3;
  assign w_pad      = 3'd0 - w_nb[2:0];
  assign w_cnt_inc  = pkt_cnt + CNT_W'(1);
  assign w_hs       = (r_state == S_SEND) && tx_ready;

  always_comb begin
    w_len_clamp = cfg_pkt_len;
    if (cfg_pkt_len < c_len_min)
      w_len_clamp = c_len_min;
    else if (cfg_pkt_len > c_len_max)
      w_len_clamp = c_len_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load_gap  = 1'b0;
    tx_valid    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (cfg_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (w_hs && w_eop) begin
          // A stop arriving with the final beat still ends the run here.
          if (r_stop || cfg_stop || (r_num != '0 && w_cnt_inc == r_num))
            w_state_nxt = S_DONE;
          else if (r_ipg != 8'd0) begin
            w_state_nxt = S_IPG;
            w_load_gap  = 1'b1;
          end
        end
      end
      S_IPG: begin
        busy = 1'b1;
        if (r_stop || cfg_stop)
          w_state_nxt = S_DONE;
        else if (r_gap == 8'd1)
          w_state_nxt = S_SEND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half  <= 1'b0;
      r_len   <= c_len_min;
      r_num   <= '0;
      r_ipg   <= 8'd0;
      r_gap   <= 8'd0;
      r_stop  <= 1'b0;
      r_off   <= '0;
      pkt_cnt <= '0;
    end else if (w_start) begin
      r_half  <= cfg_half;
      r_len   <= w_len_clamp;
      r_num   <= cfg_pkt_num;
      r_ipg   <= cfg_ipg;
      r_stop  <= 1'b0;
      r_off   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (busy && cfg_stop)
        r_stop <= 1'b1;
      if (w_hs) begin
        if (w_eop) begin
          pkt_cnt <= w_cnt_inc;
          r_off   <= '0;
        end else begin
          r_off   <= r_off + w_bpb;
        end
      end
      if (w_load_gap)
        r_gap <= r_ipg;
      else if (r_state == S_IPG)
        r_gap <= r_gap - 8'd1;
    end
  end

  // Beat contents derive only from registered state, so they hold while stalled.
  always_comb begin
    tx_data      = '0;
    tx_inframe   = '0;
    tx_eop_empty = '0;
    if (tx_valid) begin
      for (int s = 0; s < NUM_SEG; s++) begin
        for (int b = 0; b < 8; b++) begin
          if ((s * 8 + b) < int'(w_nb))
            tx_data[s*64 + b*8 +: 8] = pkt_cnt[7:0] + r_off[7:0] + 8'(s * 8 + b);
        end
        if (!w_eop && (s * 8) < int'(w_nb))
          tx_inframe[s] = 1'b1;
        else if (w_eop && (s * 8 + 8) < int'(w_nb))
          tx_inframe[s] = 1'b1;
        if (w_eop && s == int'(w_last_seg))
          tx_eop_empty[s*3 +: 3] = w_pad;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eth_f_seg_traffic_gen.sv
// Randomized and directed bench for eth_f_seg_traffic_gen against a packet-level model.
`default_nettype none

module tb_eth_f_seg_traffic_gen;

  localparam int NUM_SEG   = 16;
  localparam int PKT_LEN_W = 14;
  localparam int CNT_W     = 32;
  localparam int DW        = NUM_SEG * 64;

  logic                  clk;
  logic                  rst_n;
  logic                  cfg_start;
  logic                  cfg_stop;
  logic                  cfg_half;
  logic [PKT_LEN_W-1:0]  cfg_pkt_len;
  logic [CNT_W-1:0]      cfg_pkt_num;
  logic [7:0]            cfg_ipg;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DW-1:0]         tx_data;
  logic [NUM_SEG-1:0]    tx_inframe;
  logic [NUM_SEG*3-1:0]  tx_eop_empty;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      pkt_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 0;

  eth_f_seg_traffic_gen #(
    .NUM_SEG(NUM_SEG), .PKT_LEN_W(PKT_LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_half(cfg_half), .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_num(cfg_pkt_num),
    .cfg_ipg(cfg_ipg), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_inframe(tx_inframe), .tx_eop_empty(tx_eop_empty), .busy(busy), .done(done),
    .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 0 idle, 1 sending, 2 gap, 3 done
  int        m_st = 0;
  bit [31:0] m_cnt = 0;
  bit [31:0] m_num = 0;
  int        m_len = 64;
  int        m_off = 0;
  int        m_ipg = 0;
  int        m_gap = 0;
  bit        m_half = 0;
  bit        m_stop = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; m_off = 0; m_stop = 0;
    end else begin
      int bpb;
      bpb = m_half ? 4 * NUM_SEG : 8 * NUM_SEG;
      case (m_st)
        0, 3: if (cfg_start) begin
          m_len  = (int'(cfg_pkt_len) < 64) ? 64 : (int'(cfg_pkt_len) > 9600) ? 9600 : int'(cfg_pkt_len);
          m_half = cfg_half; m_num = cfg_pkt_num; m_ipg = int'(cfg_ipg);
          m_cnt = 0; m_off = 0; m_stop = 0; m_st = 1;
        end
        1: begin
          if (cfg_stop) m_stop = 1;
          if (tx_ready) begin
            if (m_len - m_off <= bpb) begin
              m_cnt = m_cnt + 1;
              m_off = 0;
              if (m_stop || (m_num != 0 && m_cnt == m_num)) m_st = 3;
              else if (m_ipg != 0) begin m_st = 2; m_gap = m_ipg; end
            end else begin
              m_off = m_off + bpb;
            end
          end
        end
        default: begin
          if (cfg_stop) m_stop = 1;
          if (m_stop) m_st = 3;
          else begin
            m_gap = m_gap - 1;
            if (m_gap == 0) m_st = 1;
          end
        end
      endcase
    end
  end

  logic [DW-1:0]        exp_data;
  logic [DW-1:0]        exp_mask;
  logic [NUM_SEG-1:0]   exp_inf;
  logic [NUM_SEG*3-1:0] exp_emp;

  task automatic build_exp();
    int bpb, rem, nb, last;
    exp_data = '0; exp_mask = '0; exp_inf = '0; exp_emp = '0;
    bpb  = m_half ? 4 * NUM_SEG : 8 * NUM_SEG;
    rem  = m_len - m_off;
    nb   = (rem < bpb) ? rem : bpb;
    last = (nb - 1) / 8;
    for (int k = 0; k < nb; k++) begin
      exp_data[8*k +: 8] = 8'((int'(m_cnt[7:0]) + m_off + k) % 256);
      exp_mask[8*k +: 8] = 8'hFF;
    end
    for (int k = 8 * (last + 1); k < 8 * NUM_SEG; k++)
      exp_mask[8*k +: 8] = 8'hFF;
    for (int s = 0; s <= last; s++)
      exp_inf[s] = (rem > bpb) ? 1'b1 : (s < last);
    if (rem <= bpb)
      exp_emp[3*last +: 3] = 3'((8 * ((nb + 7) / 8) - nb));
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    int bad;
    check("tx_valid", 64'(tx_valid), 64'(m_st == 1));
    check("busy", 64'(busy), 64'(m_st == 1 || m_st == 2));
    check("done", 64'(done), 64'(m_st == 3));
    check("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
    if (m_st == 1) begin
      build_exp();
      check("inframe", 64'(tx_inframe), 64'(exp_inf));
      check("eop_empty", 64'(tx_eop_empty), 64'(exp_emp));
      bad = -1;
      for (int k = 0; k < NUM_SEG * 8; k++)
        if (bad < 0 && ((tx_data[8*k +: 8] ^ exp_data[8*k +: 8]) & exp_mask[8*k +: 8]) != 8'h00)
          bad = k;
      n_checks++;
      if (bad >= 0) begin
        n_errors++;
        $display("FAIL data byte %0d got %h expected %h at %0t", bad,
                 tx_data[8*bad +: 8], exp_data[8*bad +: 8], $time);
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input bit half, input int len, input int num, input int ipg);
    @(negedge clk);
    cfg_half = half; cfg_pkt_len = PKT_LEN_W'(len); cfg_pkt_num = CNT_W'(num);
    cfg_ipg = 8'(ipg); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); cfg_stop = 1'b1;
    @(negedge clk); cfg_stop = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL done_timeout got %0d expected 1 at %0t", done, $time);
    end
  endtask

  initial begin
    int idle, guard;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_half = 1'b0;
    cfg_pkt_len = '0; cfg_pkt_num = '0; cfg_ipg = '0;
    tick(3);
    check("rst_valid", 64'(tx_valid), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_data_or", 64'(|tx_data), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Two minimum packets back-to-back, full rate
    rdy_mode = 0;
    do_start(0, 64, 2, 0);
    check("t1_valid", 64'(tx_valid), 64'd1);
    check("t1_inframe", 64'(tx_inframe), 64'h007F);
    check("t1_empty7", 64'(tx_eop_empty[23:21]), 64'd0);
    check("t1_upper", 64'(|tx_data[DW-1:512]), 64'd0);
    check("t1_byte0_p0", 64'(tx_data[7:0]), 64'h00);
    tick(1);
    check("t1_byte0_p1", 64'(tx_data[7:0]), 64'h01);
    tick(1);
    check("t1_done", 64'(done), 64'd1);
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // Half rate, 129 bytes -> 64/64/1
    do_start(1, 129, 1, 0);
    tick(2);
    check("t2_inframe", 64'(tx_inframe), 64'h0000);
    check("t2_empty0", 64'(tx_eop_empty[2:0]), 64'd7);
    check("t2_byte0", 64'(tx_data[7:0]), 64'h80);
    tick(1);
    check("t2_done", 64'(done), 64'd1);

    // Stalling sink, 100 bytes
    rdy_mode = 1;
    do_start(0, 100, 1, 0);
    check("t3_empty12", 64'(tx_eop_empty[38:36]), 64'd4);
    check("t3_inframe", 64'(tx_inframe), 64'h0FFF);
    wait_done(20);
    check("t3_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Continuous with a 3-cycle gap, then stop mid-packet
    rdy_mode = 0;
    do_start(0, 200, 0, 3);
    guard = 0;
    while (tx_valid && guard < 20) begin tick(1); guard++; end
    idle = 0;
    while (!tx_valid && idle < 20) begin tick(1); idle++; end
    check("t4_gap", 64'(idle), 64'd3);
    cfg_stop = 1'b1;
    tick(1);
    cfg_stop = 1'b0;
    wait_done(20);
    check("t4_pkt_cnt", 64'(pkt_cnt), 64'd2);
    tick(4);

    // Length clamp and start ignored while busy
    do_start(0, 20, 3, 2);
    check("t5_inframe", 64'(tx_inframe), 64'h007F);
    tick(1);
    do_start(1, 500, 9, 0);
    wait_done(50);
    check("t5_pkt_cnt", 64'(pkt_cnt), 64'd3);

    // Asynchronous reset mid-packet
    do_start(0, 1000, 0, 0);
    tick(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(tx_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("t6_inframe", 64'(tx_inframe), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("t6_post_valid", 64'(tx_valid), 64'd0);

    // Randomized runs
    rdy_mode = 2;
    for (int r = 0; r < 10; r++) begin
      int len, num;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10000)) : int'($urandom_range(1, 600));
      num = int'($urandom_range(0, 4));
      do_start(1'($urandom_range(0, 1)), len, num, int'($urandom_range(0, 3)));
      if (num == 0 || $urandom_range(0, 2) == 0) begin
        tick(int'($urandom_range(1, 40)));
        pulse_stop();
      end
      wait_done(6000);
      tick(int'($urandom_range(1, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
